spi_flash_boot_ctrl: RTL and testbench

- Sequences the byte-level SPI master to copy a boot image from external SPI flash into instruction memory after reset.
- Issues a standard READ (0x03) with a 24-bit address and streams BOOT_WORDS 32-bit words. Each word is assembled little-endian and written through a single-cycle write port.
- Holds the core in reset until the copy completes. Reports a timeout error if the SPI master stalls.

---
 rtl/spi_flash_boot_ctrl_if.sv | 22 ++
 rtl/spi_flash_boot_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_spi_flash_boot_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_boot_ctrl_if.sv
// Controller-side bundle: byte-level SPI master handshake, flash chip select and imem write port.
interface spi_flash_boot_ctrl_if;
  logic        spi_start;
  logic [7:0]  spi_tx_data;
  logic        spi_busy;
  logic        spi_done;
  logic [7:0]  spi_rx_data;
  logic        flash_cs_n;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;

  modport master (
    output spi_start, spi_tx_data, flash_cs_n, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  spi_busy, spi_done, spi_rx_data
  );

  modport slave (
    input  spi_start, spi_tx_data, flash_cs_n, mem_wr_en, mem_wr_addr, mem_wr_data,
    output spi_busy, spi_done, spi_rx_data
  );
endinterface

// File: rtl/spi_flash_boot_ctrl.sv
// Boot copier: READ 0x03 + 24-bit address, then BOOT_WORDS little-endian words into imem; core held in reset until done.
// All outputs registered; a byte is issued only while spi_busy is low; a stalled byte aborts to ERROR after TIMEOUT.
module spi_flash_boot_ctrl #(
  parameter int unsigned BOOT_WORDS = 256,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter logic [31:0] MEM_BASE   = 32'h0000_0000,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                         sclk,
  input  logic                         rst_n,
  input  logic                         boot_start,
  spi_flash_boot_ctrl_if.master        bus,
  output logic                         core_rst_n,
  output logic                         boot_done,
  output logic                         boot_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_CS_SETUP, S_CMD, S_ADDR2, S_ADDR1, S_ADDR0,
    S_DATA, S_WRITE, S_CS_HOLD, S_DONE, S_ERROR
  } state_e;

  localparam logic [15:0] LAST_WORD  = 16'(BOOT_WORDS - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT - 1);

  state_e      state_q, state_d, adv_state;
  logic        cs_n_q, cs_n_d;
  logic        start_q, start_d;
  logic [7:0]  tx_q, tx_d, next_byte;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        core_rst_n_q, core_rst_n_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [31:0] word_buf_q, word_buf_d;
  logic        pend_q, pend_d;
  logic [31:0] tmo_q, tmo_d;

  always_comb begin
    next_byte = 8'h00;
    adv_state = state_q;
    case (state_q)
      S_CMD:   begin next_byte = 8'h03;             adv_state = S_ADDR2; end
      S_ADDR2: begin next_byte = FLASH_BASE[23:16]; adv_state = S_ADDR1; end
      S_ADDR1: begin next_byte = FLASH_BASE[15:8];  adv_state = S_ADDR0; end
      S_ADDR0: begin next_byte = FLASH_BASE[7:0];   adv_state = S_DATA;  end
      S_DATA:  begin
        next_byte = 8'h00;
        adv_state = (byte_cnt_q == 2'd3) ? S_WRITE : S_DATA;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cs_n_d       = cs_n_q;
    start_d      = 1'b0;
    tx_d         = tx_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    core_rst_n_d = core_rst_n_q;
    done_d       = done_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    byte_cnt_d   = byte_cnt_q;
    word_idx_d   = word_idx_q;
    word_buf_d   = word_buf_q;
    pend_d       = pend_q;
    tmo_d        = tmo_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (boot_start) begin
          state_d      = S_CS_SETUP;
          cs_n_d       = 1'b0;
          err_d        = 1'b0;
          done_d       = 1'b0;
          core_rst_n_d = 1'b0;
          cnt_d        = 16'd0;
          byte_cnt_d   = 2'd0;
          word_idx_d   = 16'd0;
          pend_d       = 1'b0;
          tmo_d        = 32'd0;
        end
      end
      S_CS_SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = S_CMD;
        else                     cnt_d   = cnt_q + 16'd1;
      end
      S_CMD, S_ADDR2, S_ADDR1, S_ADDR0, S_DATA: begin
        // pend_q guarantees one start per byte and filters stray spi_done pulses
        if (pend_q) begin
          if (bus.spi_done) begin
            pend_d  = 1'b0;
            state_d = adv_state;
            if (state_q == S_DATA) begin
              word_buf_d[{byte_cnt_q, 3'b000} +: 8] = bus.spi_rx_data;
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_d = S_ERROR;
            cs_n_d  = 1'b1;
            err_d   = 1'b1;
            pend_d  = 1'b0;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end else if (!bus.spi_busy) begin
          start_d = 1'b1;
          tx_d    = next_byte;
          pend_d  = 1'b1;
          tmo_d   = 32'd0;
        end
      end
      S_WRITE: begin
        wr_en_d    = 1'b1;
        wr_addr_d  = MEM_BASE + {14'd0, word_idx_q, 2'b00};
        wr_data_d  = word_buf_q;
        word_idx_d = word_idx_q + 16'd1;
        if (word_idx_q == LAST_WORD) begin
          state_d = S_CS_HOLD;
          cnt_d   = 16'd0;
        end else begin
          state_d = S_DATA;
        end
      end
      S_CS_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d      = S_DONE;
          cs_n_d       = 1'b1;
          done_d       = 1'b1;
          core_rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cs_n_q       <= 1'b1;
      start_q      <= 1'b0;
      tx_q         <= 8'h00;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 32'd0;
      wr_data_q    <= 32'd0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= 16'd0;
      byte_cnt_q   <= 2'd0;
      word_idx_q   <= 16'd0;
      word_buf_q   <= 32'd0;
      pend_q       <= 1'b0;
      tmo_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      cs_n_q       <= cs_n_d;
      start_q      <= start_d;
      tx_q         <= tx_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      word_buf_q   <= word_buf_d;
      pend_q       <= pend_d;
      tmo_q        <= tmo_d;
    end
  end

  assign bus.spi_start   = start_q;
  assign bus.spi_tx_data = tx_q;
  assign bus.flash_cs_n  = cs_n_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_addr = wr_addr_q;
  assign bus.mem_wr_data = wr_data_q;
  assign core_rst_n      = core_rst_n_q;
  assign boot_done       = done_q;
  assign boot_err        = err_q;

endmodule

// File: tb/tb_spi_flash_boot_ctrl.sv
// Bench: flash model with scoreboard queues for transmitted bytes and memory writes; dut_a copies 2 words, dut_b 1 word.
module tb_spi_flash_boot_ctrl;
  localparam logic [23:0] FB = 24'h001000;
  localparam logic [77:0] RST_VAL = {1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0, 3'b000};

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic rst_n, boot_start_a, boot_start_b;
  logic core_rst_n_a, boot_done_a, boot_err_a;
  logic core_rst_n_b, boot_done_b, boot_err_b;

  spi_flash_boot_ctrl_if bus_a ();
  spi_flash_boot_ctrl_if bus_b ();

  spi_flash_boot_ctrl #(.BOOT_WORDS(2), .FLASH_BASE(FB), .MEM_BASE(32'h0),
                        .CS_SETUP(2), .CS_HOLD(2), .TIMEOUT(16)) dut_a (
    .sclk(sclk), .rst_n(rst_n), .boot_start(boot_start_a), .bus(bus_a),
    .core_rst_n(core_rst_n_a), .boot_done(boot_done_a), .boot_err(boot_err_a));

  spi_flash_boot_ctrl #(.BOOT_WORDS(1), .FLASH_BASE(FB), .MEM_BASE(32'h0),
                        .CS_SETUP(2), .CS_HOLD(2), .TIMEOUT(16)) dut_b (
    .sclk(sclk), .rst_n(rst_n), .boot_start(boot_start_b), .bus(bus_b),
    .core_rst_n(core_rst_n_b), .boot_done(boot_done_b), .boot_err(boot_err_b));

  logic       sel;
  logic       m_busy, m_done;
  logic [7:0] m_rx;
  assign bus_a.spi_busy    = sel ? 1'b0 : m_busy;
  assign bus_a.spi_done    = sel ? 1'b0 : m_done;
  assign bus_a.spi_rx_data = m_rx;
  assign bus_b.spi_busy    = sel ? m_busy : 1'b0;
  assign bus_b.spi_done    = sel ? m_done : 1'b0;
  assign bus_b.spi_rx_data = m_rx;

  logic        o_start, o_cs_n, o_wr_en, o_core_rst_n, o_done, o_err;
  logic [7:0]  o_tx;
  logic [31:0] o_wr_addr, o_wr_data;
  assign o_start      = sel ? bus_b.spi_start   : bus_a.spi_start;
  assign o_cs_n       = sel ? bus_b.flash_cs_n  : bus_a.flash_cs_n;
  assign o_wr_en      = sel ? bus_b.mem_wr_en   : bus_a.mem_wr_en;
  assign o_tx         = sel ? bus_b.spi_tx_data : bus_a.spi_tx_data;
  assign o_wr_addr    = sel ? bus_b.mem_wr_addr : bus_a.mem_wr_addr;
  assign o_wr_data    = sel ? bus_b.mem_wr_data : bus_a.mem_wr_data;
  assign o_core_rst_n = sel ? core_rst_n_b : core_rst_n_a;
  assign o_done       = sel ? boot_done_b  : boot_done_a;
  assign o_err        = sel ? boot_err_b   : boot_err_a;

  int vectors = 0, miscompares = 0;
  int start_cnt = 0, wr_cnt = 0, cyc = 0, last_start_cyc = 0;
  int drop_at = -1, pre_busy = 0;
  logic [7:0]  exp_tx_q[$];
  logic [63:0] exp_wr_q[$];
  logic [7:0]  img[8];

  always @(posedge sclk) cyc <= cyc + 1;

  // Flash + SPI master model and scoreboard consumer
  initial begin
    int byte_no, lat, pre_cnt;
    bit xfer;
    logic [7:0] cur_tx, exp_b;
    logic [63:0] exp_w;
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h67, 8'h80, 8'h00, 8'h00};
    m_busy = 1'b0; m_done = 1'b0; m_rx = 8'h00;
    byte_no = 0; lat = 0; pre_cnt = 0; xfer = 1'b0; cur_tx = 8'h00;
    forever begin
      @(negedge sclk);
      m_done = 1'b0;
      if (o_wr_en === 1'b1) begin
        wr_cnt++; vectors++;
        if (exp_wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL write_unexpected: got addr %h data %h, required no write", o_wr_addr, o_wr_data);
        end else begin
          exp_w = exp_wr_q.pop_front();
          if ({o_wr_addr, o_wr_data} !== exp_w) begin
            miscompares++;
            $display("FAIL write_value: got %h/%h, required %h/%h", o_wr_addr, o_wr_data, exp_w[63:32], exp_w[31:0]);
          end
        end
      end
      if (o_start === 1'b1) begin
        start_cnt++; last_start_cyc = cyc; vectors++;
        if (exp_tx_q.size() == 0) begin
          miscompares++;
          $display("FAIL tx_unexpected: got byte %h, required no start", o_tx);
        end else begin
          exp_b = exp_tx_q.pop_front();
          if (o_tx !== exp_b) begin
            miscompares++;
            $display("FAIL tx_byte: got %h, required %h", o_tx, exp_b);
          end
        end
        vectors++;
        if (m_busy !== 1'b0 || xfer || o_cs_n !== 1'b0) begin
          miscompares++;
          $display("FAIL start_cond: got busy=%b inflight=%b cs_n=%b, required 0 0 0", m_busy, xfer, o_cs_n);
        end
      end
      if (!rst_n || o_cs_n === 1'b1) begin
        xfer = 1'b0; m_busy = 1'b0; byte_no = 0; pre_cnt = pre_busy;
      end else if (o_start === 1'b1) begin
        xfer = 1'b1; lat = 3; cur_tx = o_tx; m_busy = 1'b1;
      end else if (xfer) begin
        vectors++;
        if (o_tx !== cur_tx) begin
          miscompares++;
          $display("FAIL tx_stable: got %h, required %h", o_tx, cur_tx);
        end
        if (byte_no != drop_at) begin
          if (lat > 1) lat--;
          else begin
            m_done = 1'b1;
            m_rx = (byte_no >= 4) ? img[(byte_no - 4) % 8] : 8'hFF;
            xfer = 1'b0; byte_no++; pre_cnt = pre_busy; m_busy = (pre_busy > 0);
          end
        end
      end else if (pre_cnt > 0) begin
        m_busy = 1'b1; pre_cnt--;
      end else begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic push_tx(input int n_data);
    exp_tx_q.push_back(8'h03);
    exp_tx_q.push_back(FB[23:16]);
    exp_tx_q.push_back(FB[15:8]);
    exp_tx_q.push_back(FB[7:0]);
    for (int i = 0; i < n_data; i++) exp_tx_q.push_back(8'h00);
  endtask

  task automatic pulse_start();
    @(negedge sclk);
    if (sel) boot_start_b = 1'b1; else boot_start_a = 1'b1;
    @(negedge sclk);
    boot_start_a = 1'b0; boot_start_b = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    bit seen_low;
    n = 0; seen_low = 1'b0;
    while (o_done !== 1'b1 && n < 2000) begin
      @(negedge sclk); n++;
      if (o_done !== 1'b1) begin
        if (seen_low) begin
          vectors++;
          if (o_cs_n !== 1'b0) begin
            miscompares++;
            $display("FAIL %s cs_n_mid_stream: got %b, required 0", name, o_cs_n);
          end
        end else if (o_cs_n === 1'b0) seen_low = 1'b1;
      end
    end
    vectors++;
    if (o_done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done_timeout: got boot_done=%b, required 1", name, o_done);
    end else begin
      vectors++;
      if ({o_cs_n, o_core_rst_n, o_err} !== 3'b110) begin
        miscompares++;
        $display("FAIL %s done_outputs: got cs_n,core_rst_n,err=%b, required 110", name, {o_cs_n, o_core_rst_n, o_err});
      end
    end
  endtask

  task automatic check_counts(input string name, input int ds, input int dw, input int es, input int ew);
    vectors++;
    if (ds != es || dw != ew || exp_tx_q.size() != 0 || exp_wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s counts: got starts=%0d writes=%0d left=%0d/%0d, required %0d %0d 0/0",
               name, ds, dw, exp_tx_q.size(), exp_wr_q.size(), es, ew);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge sclk);
    vectors++;
    if ({bus_a.flash_cs_n, bus_a.spi_start, bus_a.spi_tx_data, bus_a.mem_wr_en, bus_a.mem_wr_addr,
         bus_a.mem_wr_data, core_rst_n_a, boot_done_a, boot_err_a} !== RST_VAL) begin
      miscompares++;
      $display("FAIL reset_a: got %h, required %h", {bus_a.flash_cs_n, bus_a.spi_start, bus_a.spi_tx_data,
               bus_a.mem_wr_en, bus_a.mem_wr_addr, bus_a.mem_wr_data, core_rst_n_a, boot_done_a, boot_err_a}, RST_VAL);
    end
    vectors++;
    if ({bus_b.flash_cs_n, bus_b.spi_start, bus_b.spi_tx_data, bus_b.mem_wr_en, bus_b.mem_wr_addr,
         bus_b.mem_wr_data, core_rst_n_b, boot_done_b, boot_err_b} !== RST_VAL) begin
      miscompares++;
      $display("FAIL reset_b: got %h, required %h", {bus_b.flash_cs_n, bus_b.spi_start, bus_b.spi_tx_data,
               bus_b.mem_wr_en, bus_b.mem_wr_addr, bus_b.mem_wr_data, core_rst_n_b, boot_done_b, boot_err_b}, RST_VAL);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge sclk);
  endtask

  task automatic test_nominal();
    int s0, w0;
    sel = 1'b0; drop_at = -1; pre_busy = 0;
    s0 = start_cnt; w0 = wr_cnt;
    push_tx(8);
    exp_wr_q.push_back({32'h0, 32'h0000_0013});
    exp_wr_q.push_back({32'h4, 32'h0000_8067});
    pulse_start();
    wait_done("nominal");
    check_counts("nominal", start_cnt - s0, wr_cnt - w0, 12, 2);
  endtask

  task automatic test_timeout();
    int s0, w0, n;
    drop_at = 6;
    s0 = start_cnt; w0 = wr_cnt;
    push_tx(3);
    pulse_start();
    vectors++;
    if ({o_done, o_core_rst_n} !== 2'b00) begin
      miscompares++;
      $display("FAIL rerun_clear: got done,core_rst_n=%b, required 00", {o_done, o_core_rst_n});
    end
    n = 0;
    while (o_err !== 1'b1 && n < 500) begin @(negedge sclk); n++; end
    vectors++;
    if (o_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_err: got boot_err=%b, required 1", o_err);
    end else begin
      vectors++;
      if (cyc - last_start_cyc != 16) begin
        miscompares++;
        $display("FAIL timeout_latency: got %0d cycles, required 16", cyc - last_start_cyc);
      end
      vectors++;
      if ({o_cs_n, o_core_rst_n, o_done} !== 3'b100) begin
        miscompares++;
        $display("FAIL timeout_outputs: got cs_n,core_rst_n,done=%b, required 100", {o_cs_n, o_core_rst_n, o_done});
      end
    end
    repeat (10) @(negedge sclk);
    check_counts("timeout", start_cnt - s0, wr_cnt - w0, 7, 0);
    drop_at = -1;
  endtask

  task automatic test_retry();
    int s0, w0;
    s0 = start_cnt; w0 = wr_cnt;
    push_tx(8);
    exp_wr_q.push_back({32'h0, 32'h0000_0013});
    exp_wr_q.push_back({32'h4, 32'h0000_8067});
    pulse_start();
    vectors++;
    if (o_err !== 1'b0) begin
      miscompares++;
      $display("FAIL retry_err_clear: got boot_err=%b, required 0", o_err);
    end
    wait_done("retry");
    check_counts("retry", start_cnt - s0, wr_cnt - w0, 12, 2);
  endtask

  task automatic test_reset_mid_data();
    int s0, w0, n;
    s0 = start_cnt; w0 = wr_cnt;
    push_tx(6);
    exp_wr_q.push_back({32'h0, 32'h0000_0013});
    pulse_start();
    n = 0;
    while (start_cnt - s0 < 10 && n < 500) begin @(negedge sclk); n++; end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus_a.flash_cs_n, bus_a.spi_start, bus_a.spi_tx_data, bus_a.mem_wr_en, bus_a.mem_wr_addr,
         bus_a.mem_wr_data, core_rst_n_a, boot_done_a, boot_err_a} !== RST_VAL) begin
      miscompares++;
      $display("FAIL reset_mid: got %h, required %h", {bus_a.flash_cs_n, bus_a.spi_start, bus_a.spi_tx_data,
               bus_a.mem_wr_en, bus_a.mem_wr_addr, bus_a.mem_wr_data, core_rst_n_a, boot_done_a, boot_err_a}, RST_VAL);
    end
    repeat (4) @(negedge sclk);
    check_counts("reset_mid", start_cnt - s0, wr_cnt - w0, 10, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge sclk);
    s0 = start_cnt; w0 = wr_cnt;
    push_tx(8);
    exp_wr_q.push_back({32'h0, 32'h0000_0013});
    exp_wr_q.push_back({32'h4, 32'h0000_8067});
    pulse_start();
    wait_done("after_reset");
    check_counts("after_reset", start_cnt - s0, wr_cnt - w0, 12, 2);
  endtask

  task automatic test_start_while_busy();
    int s0, w0, n;
    s0 = start_cnt; w0 = wr_cnt;
    push_tx(8);
    exp_wr_q.push_back({32'h0, 32'h0000_0013});
    exp_wr_q.push_back({32'h4, 32'h0000_8067});
    pulse_start();
    n = 0;
    while (start_cnt - s0 < 3 && n < 500) begin @(negedge sclk); n++; end
    pulse_start();
    wait_done("busy_start");
    check_counts("busy_start", start_cnt - s0, wr_cnt - w0, 12, 2);
  endtask

  task automatic test_busy_boundary();
    int s0, w0;
    sel = 1'b1; pre_busy = 5; drop_at = -1;
    repeat (2) @(negedge sclk);
    s0 = start_cnt; w0 = wr_cnt;
    push_tx(4);
    exp_wr_q.push_back({32'h0, 32'h0000_0013});
    pulse_start();
    wait_done("busy_boundary");
    check_counts("busy_boundary", start_cnt - s0, wr_cnt - w0, 8, 1);
    pre_busy = 0; sel = 1'b0;
  endtask

  initial begin
    sel = 1'b0; rst_n = 1'b0; boot_start_a = 1'b0; boot_start_b = 1'b0;
    test_reset();
    test_nominal();
    test_timeout();
    test_retry();
    test_reset_mid_data();
    test_start_while_busy();
    test_busy_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
